// File: rtl/kgd_sync_gen_if.sv
// kgd_sync_gen_if: raster timing bundle from the KSM sync generator to the KGD
// graphics/text controllers.
//   col        11  current column
//   row        10  current line
//   hsync       1  horizontal sync (level per HS_POL)
//   vsync       1  vertical sync (level per VS_POL)
//   de          1  display enable, visible window
//   line_end    1  strobe on last column of every line
//   frame_end   1  strobe on last column of last line
//   frame_cnt   8  frames completed since reset
//   blink       1  cursor blink flag
// master: the generator drives the bundle; slave: a consumer samples it.
interface kgd_sync_gen_if;
  logic [10:0] col;
  logic [9:0]  row;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        line_end;
  logic        frame_end;
  logic [7:0]  frame_cnt;
  logic        blink;

  modport master (
    output col, row, hsync, vsync, de, line_end, frame_end, frame_cnt, blink
  );

  modport slave (
    input col, row, hsync, vsync, de, line_end, frame_end, frame_cnt, blink
  );
endinterface

// File: rtl/kgd_sync_gen.sv
// kgd_sync_gen: video timing generator (KSM sync). Runs the col/row raster
// counters and decodes sync, display enable, line/frame strobes and the
// frame-rate cursor blink flag.
//   i_clk50   in   pixel/system clock
//   i_vreset  in   synchronous active-high reset
//   o_vid     out  raster bundle (kgd_sync_gen_if.master)
// Every decode is computed from the next counter values and registered in the
// same edge as the counters, so each cycle's decodes describe that cycle's
// col/row with no skew.
module kgd_sync_gen #(
  parameter int unsigned H_TOTAL   = 1056,
  parameter int unsigned H_ACT_BEG = 40,
  parameter int unsigned H_ACT_END = 839,
  parameter int unsigned HS_BEG    = 928,
  parameter int unsigned V_TOTAL   = 628,
  parameter int unsigned V_ACT_BEG = 23,
  parameter int unsigned V_ACT_END = 622,
  parameter int unsigned VS_BEG    = 624,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned BLINK_BIT = 5
) (
  input  logic                  i_clk50,
  input  logic                  i_vreset,
  kgd_sync_gen_if.master        o_vid
);

  localparam logic [10:0] L_H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] L_H_ACT_BEG = 11'(H_ACT_BEG);
  localparam logic [10:0] L_H_ACT_END = 11'(H_ACT_END);
  localparam logic [10:0] L_HS_BEG    = 11'(HS_BEG);
  localparam logic [9:0]  L_V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  L_V_ACT_BEG = 10'(V_ACT_BEG);
  localparam logic [9:0]  L_V_ACT_END = 10'(V_ACT_END);
  localparam logic [9:0]  L_VS_BEG    = 10'(VS_BEG);
  localparam logic [2:0]  L_BLINK_IDX = 3'(BLINK_BIT);

  logic [10:0] r_col;
  logic [9:0]  r_row;
  logic [7:0]  r_frame_cnt;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic        r_line_end;
  logic        r_frame_end;
  logic        r_blink;

  logic [10:0] w_col_nxt;
  logic [9:0]  w_row_nxt;
  logic [7:0]  w_frame_cnt_nxt;
  logic        w_line_last;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;
  logic        w_de_nxt;
  logic        w_line_end_nxt;
  logic        w_frame_end_nxt;

  // Raster advance; >= keeps the wrap safe even if a counter were ever out of range.
  always_comb begin
    w_line_last     = (r_col >= L_H_LAST);
    w_col_nxt       = r_col + 11'd1;
    w_row_nxt       = r_row;
    w_frame_cnt_nxt = r_frame_cnt;
    if (w_line_last) begin
      w_col_nxt = '0;
      if (r_row >= L_V_LAST) begin
        w_row_nxt       = '0;
        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
      end else begin
        w_row_nxt = r_row + 10'd1;
      end
    end
  end

  // Decodes of the position that will be presented next cycle.
  always_comb begin
    w_hsync_nxt     = (w_col_nxt >= L_HS_BEG) ? HS_POL : ~HS_POL;
    w_vsync_nxt     = (w_row_nxt >= L_VS_BEG) ? VS_POL : ~VS_POL;
    w_de_nxt        = (w_col_nxt >= L_H_ACT_BEG) && (w_col_nxt <= L_H_ACT_END) &&
                      (w_row_nxt >= L_V_ACT_BEG) && (w_row_nxt <= L_V_ACT_END);
    w_line_end_nxt  = (w_col_nxt == L_H_LAST);
    w_frame_end_nxt = w_line_end_nxt && (w_row_nxt == L_V_LAST);
  end

  // Counter and decode registers.
  always_ff @(posedge i_clk50) begin
    if (i_vreset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_frame_cnt <= '0;
      r_hsync     <= ~HS_POL;
      r_vsync     <= ~VS_POL;
      r_de        <= 1'b0;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_hsync     <= w_hsync_nxt;
      r_vsync     <= w_vsync_nxt;
      r_de        <= w_de_nxt;
      r_line_end  <= w_line_end_nxt;
      r_frame_end <= w_frame_end_nxt;
      // Follows the counter bit, so it can only change at a frame boundary.
      r_blink     <= w_frame_cnt_nxt[L_BLINK_IDX];
    end
  end

  assign o_vid.col       = r_col;
  assign o_vid.row       = r_row;
  assign o_vid.hsync     = r_hsync;
  assign o_vid.vsync     = r_vsync;
  assign o_vid.de        = r_de;
  assign o_vid.line_end  = r_line_end;
  assign o_vid.frame_end = r_frame_end;
  assign o_vid.frame_cnt = r_frame_cnt;
  assign o_vid.blink     = r_blink;

endmodule
